// File: rtl/spi_ram_param.sv
// Command-driven single-port RAM slave behind the SPI front end: separate
// write/read pointers, optional burst auto-increment, registered read data.
module spi_ram_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err
);

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d, cmd_err_q, cmd_err_d;
  logic                  mem_we;

  cmd_e                  cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_ok;

  assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign addr    = din[ADDR_WIDTH-1:0];
  assign addr_ok = {1'b0, addr} < DEPTH_W;

  // Burst step; wrapping from the last word is silent.
  function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
    if (!AUTO_INC) return p;
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WADDR: if (addr_ok) begin
                     wr_ptr_d = addr;
                     wr_vld_d = 1'b1;
                   end else cmd_err_d = 1'b1;
        CMD_WDATA: if (wr_vld_q) begin
                     mem_we   = 1'b1;
                     wr_ptr_d = bump(wr_ptr_q);
                   end else cmd_err_d = 1'b1;
        CMD_RADDR: if (addr_ok) begin
                     rd_ptr_d = addr;
                     rd_vld_d = 1'b1;
                   end else cmd_err_d = 1'b1;
        CMD_RDATA: if (rd_vld_q) begin
                     dout_d     = mem[rd_ptr_q];
                     tx_valid_d = 1'b1;
                     rd_ptr_d   = bump(rd_ptr_q);
                   end else cmd_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Storage survives reset so data written before a reset can be read back.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= din[DATA_WIDTH-1:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_param.sv
// Scoreboard bench: three configurations driven by one command model; each
// accepted command queues the expected next-cycle outputs.
module tb_spi_ram_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  din0 = '0, din1 = '0;
  logic [17:0] din2 = '0;
  logic        rxv0 = 1'b0, rxv1 = 1'b0, rxv2 = 1'b0;
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic        tx0, tx1, tx2, err0, err1, err2;

  spi_ram_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .rx_valid(rxv0),
    .dout(dout0), .tx_valid(tx0), .cmd_err(err0));
  spi_ram_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .rx_valid(rxv1),
    .dout(dout1), .tx_valid(tx1), .cmd_err(err1));
  spi_ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .MEM_DEPTH(16), .AUTO_INC(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .rx_valid(rxv2),
    .dout(dout2), .tx_valid(tx2), .cmd_err(err2));

  typedef struct {
    logic        tx;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   n_vec = 0, n_err = 0;

  // Reference model, one slot per instance
  int          depth[3] = '{256, 200, 16};
  int          aw[3]    = '{8, 8, 4};
  int          dw[3]    = '{8, 8, 16};
  bit          ai[3]    = '{1'b1, 1'b1, 1'b0};
  int          wp[3], rp[3];
  bit          wv[3], rv[3];
  logic [15:0] ld[3];
  logic [15:0] mm[3][256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0; rp[d] = 0; wv[d] = 1'b0; rv[d] = 1'b0; ld[d] = '0;
    end
  endfunction

  function automatic int nxt(input int d, input int p);
    if (!ai[d]) return p;
    return (p == depth[d] - 1) ? 0 : p + 1;
  endfunction

  // Drive one cycle on instance d; queue the outputs expected one cycle later.
  task automatic step(input int d, input bit v, input logic [1:0] c, input logic [15:0] pl);
    exp_t        e;
    int          a;
    logic [15:0] dm;
    case (d)
      0: begin rxv0 = v; din0 = {c, pl[7:0]}; end
      1: begin rxv1 = v; din1 = {c, pl[7:0]}; end
      default: begin rxv2 = v; din2 = {c, pl}; end
    endcase
    @(posedge clk);
    a  = int'(pl) & ((1 << aw[d]) - 1);
    dm = (dw[d] == 16) ? 16'hFFFF : 16'h00FF;
    e.tx = 1'b0; e.err = 1'b0;
    if (v) begin
      case (c)
        2'b00: if (a < depth[d]) begin wp[d] = a; wv[d] = 1'b1; end else e.err = 1'b1;
        2'b01: if (wv[d]) begin mm[d][wp[d]] = pl & dm; wp[d] = nxt(d, wp[d]); end
               else e.err = 1'b1;
        2'b10: if (a < depth[d]) begin rp[d] = a; rv[d] = 1'b1; end else e.err = 1'b1;
        default: if (rv[d]) begin ld[d] = mm[d][rp[d]]; e.tx = 1'b1; rp[d] = nxt(d, rp[d]); end
                 else e.err = 1'b1;
      endcase
    end
    e.data = ld[d];
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    rxv0 = 1'b0; rxv1 = 1'b0; rxv2 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("u0.tx_valid", 32'(tx0), 32'(e.tx));
      chk("u0.cmd_err", 32'(err0), 32'(e.err));
      chk("u0.dout", 32'(dout0), 32'(e.data));
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("u1.tx_valid", 32'(tx1), 32'(e.tx));
      chk("u1.cmd_err", 32'(err1), 32'(e.err));
      chk("u1.dout", 32'(dout1), 32'(e.data));
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk("u2.tx_valid", 32'(tx2), 32'(e.tx));
      chk("u2.cmd_err", 32'(err2), 32'(e.err));
      chk("u2.dout", 32'(dout2), 32'(e.data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.u0", {tx0, err0, 8'h0, dout0}, 32'h0);
    chk("rst.u1", {tx1, err1, 8'h0, dout1}, 32'h0);
    chk("rst.u2", {tx2, err2, dout2}, 32'h0);
    rst_n = 1'b1;

    // Data/read commands with no address loaded are rejected
    step(0, 1, 2'b01, 16'h55);
    step(0, 1, 2'b11, 16'h00);
    step(0, 0, 2'b00, 16'h00);

    // Basic write then read
    step(0, 1, 2'b00, 16'h10);
    step(0, 1, 2'b01, 16'hA5);
    step(0, 1, 2'b10, 16'h10);
    step(0, 1, 2'b11, 16'h00);
    step(0, 0, 2'b00, 16'h00);

    // Burst across the top of memory, then back-to-back reads
    step(0, 1, 2'b00, 16'hFE);
    step(0, 1, 2'b01, 16'h11);
    step(0, 1, 2'b01, 16'h22);
    step(0, 1, 2'b01, 16'h33);
    step(0, 1, 2'b10, 16'hFE);
    step(0, 1, 2'b11, 16'h00);
    step(0, 1, 2'b11, 16'h00);
    step(0, 1, 2'b11, 16'h00);
    step(0, 0, 2'b00, 16'h00);

    // Out-of-range address on the 200-deep instance
    step(1, 1, 2'b00, 16'hC8);
    step(1, 1, 2'b01, 16'h77);
    step(1, 1, 2'b10, 16'hC8);
    step(1, 1, 2'b00, 16'hC7);
    step(1, 1, 2'b01, 16'h77);
    step(1, 1, 2'b01, 16'h88);
    step(1, 1, 2'b10, 16'hC7);
    step(1, 1, 2'b11, 16'h00);
    step(1, 1, 2'b11, 16'h00);

    // Wide data, no auto-increment, high address bits ignored
    step(2, 1, 2'b00, 16'h0003);
    step(2, 1, 2'b01, 16'hBEEF);
    step(2, 1, 2'b10, 16'h0003);
    step(2, 1, 2'b11, 16'h0000);
    step(2, 1, 2'b11, 16'h0000);
    step(2, 1, 2'b00, 16'hFFF3);
    step(2, 1, 2'b01, 16'h1234);
    step(2, 1, 2'b10, 16'hFFF3);
    step(2, 1, 2'b11, 16'h0000);

    // Reset while a read pulse is on the outputs
    step(0, 1, 2'b10, 16'h10);
    step(0, 1, 2'b11, 16'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.tx_valid", 32'(tx0), 32'h0);
    chk("rstmid.dout", 32'(dout0), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 2'b10, 16'h10);
    step(0, 1, 2'b11, 16'h00);
    step(0, 1, 2'b10, 16'h00);
    step(0, 1, 2'b11, 16'h00);
    step(0, 0, 2'b00, 16'h00);

    repeat (2) @(negedge clk);
    chk("sb.drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_param.md
# spi_ram_param

Parametrised single-port RAM slave for the SPI-RAM subsystem. It receives command-tagged words from the SPI slave front end on `din`/`rx_valid`, writes and reads an internal memory, and returns read data on `dout` with a one-cycle `tx_valid` pulse. It replaces the fixed 8-bit / 256-deep RAM. New capabilities are configurable address and data widths, independent write and read pointers with optional auto-increment (burst access), and a command-error pulse.

## Interface
- `ADDR_WIDTH`, 8, address bits. Must satisfy `ADDR_WIDTH <= DATA_WIDTH`.
- `DATA_WIDTH`, 8, memory word width.
- `MEM_DEPTH`, 256, number of words. Must satisfy `1 <= MEM_DEPTH <= 2**ADDR_WIDTH`.
- `AUTO_INC`, 1, when 1 the write and read pointers advance after every data access.

Ports:
- `clk`  in  1  clock; all logic samples on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_WIDTH+2  bits [DATA_WIDTH+1:DATA_WIDTH] carry the command; bits [DATA_WIDTH-1:0] carry the payload.
- `rx_valid`  in  1  `din` is valid this cycle.
- `dout`  out  DATA_WIDTH  read data.
- `tx_valid`  out  1  `dout` is valid; a one-cycle pulse.
- `cmd_err`  out  1  one-cycle pulse marking a rejected command.

## Operation
A command is accepted on a rising edge where `rx_valid` is 1. At most one command is processed per cycle. `cmd` refers to `din[DATA_WIDTH+1:DATA_WIDTH]`.

- **cmd 00, write address:**
  - If `din[ADDR_WIDTH-1:0] < MEM_DEPTH`: `wr_ptr` is loaded and `wr_vld` is set to 1.
  - Otherwise: `cmd_err` pulses and `wr_ptr`/`wr_vld` are unchanged.
- **cmd 01, write data:**
  - If `wr_vld` is 1: `mem[wr_ptr]` is loaded from `din[DATA_WIDTH-1:0]`. If `AUTO_INC` is 1, `wr_ptr` then increments.
  - If `wr_vld` is 0: `cmd_err` pulses and memory is unchanged.
- **cmd 10, read address:** same as cmd 00, applied to `rd_ptr`/`rd_vld`.
- **cmd 11, read data:**
  - If `rd_vld` is 1: `dout` is loaded with `mem[rd_ptr]` and `tx_valid` pulses. If `AUTO_INC` is 1, `rd_ptr` then increments. The payload bits are ignored.
  - If `rd_vld` is 0: `cmd_err` pulses, and `dout`/`tx_valid` stay unchanged (`tx_valid` stays 0).
- **Pointer wrap:** a pointer increment from `MEM_DEPTH-1` wraps to 0 and does not raise an error.
- **Independent pointers:** write and read pointers never affect each other.
- **Payload bits above the address:** bits above `ADDR_WIDTH-1` of an address payload are ignored.
- **`rx_valid` = 0:** no state change. `tx_valid` and `cmd_err` are 0 in the next cycle.
- **Memory contents:** not reset; undefined until written.

## Timing
- **Reset values while `rst_n` = 0:** `dout` = 0, `tx_valid` = 0, `cmd_err` = 0, `wr_ptr` = 0, `rd_ptr` = 0, `wr_vld` = 0, `rd_vld` = 0.
- **Reset release:** commands are accepted from the first rising edge after `rst_n` rises.
- **Read latency:** a read command accepted at edge N gives `dout` and `tx_valid` = 1 from edge N+1, so they are seen one cycle after the command. `tx_valid` drops at edge N+2 unless another read is accepted at N+1.
- **Back-to-back reads:** a read accepted on every edge gives `tx_valid` held at 1 and a new word on `dout` each cycle.
- **`dout` hold:** `dout` keeps its last value when `tx_valid` is 0.
- **Write timing:** a write is committed at the accepting edge. A read of the same location accepted at the very next edge returns the new data; no bypass logic is needed.
- **`cmd_err` timing:** `cmd_err` is registered and is 1 for the cycle after the offending edge.
- **Reset mid-operation:** asserting `rst_n` immediately clears all outputs and pointers, including a `tx_valid` pulse in flight. Memory is retained.

## Test plan
- **Basic write/read:** reset, then send 00/0x10, 01/0xA5, 10/0x10, 11. Expect `tx_valid` = 1 with `dout` = 0xA5 one cycle after the read command. `cmd_err` never pulses.
- **Write burst with wrap (`AUTO_INC` = 1, `MEM_DEPTH` = 256):**
  - Send 00/0xFE, then 01 with 0x11, 0x22, 0x33.
  - Then send 10/0xFE and three consecutive 11 commands.
  - Expect `dout` = 0x11, 0x22, 0x33 on three consecutive cycles with `tx_valid` held at 1; the third word comes from address 0x00.
- **Error on missing address:** directly after reset, send 01/0x55 and 11. Expect one `cmd_err` pulse after each, `tx_valid` held at 0, and `dout` = 0.
- **Error on out-of-range address (`MEM_DEPTH` = 200):** send 00/0xC8. Expect a `cmd_err` pulse; `wr_vld` stays 0, so a following 01 also flags an error.
- **Reset mid-read:** assert `rst_n` low in the cycle where `tx_valid` = 1. Expect `tx_valid` and `dout` to become 0 immediately. After release, read the earlier address again (re-loaded with 10) and expect the data written before the reset.
- **Generic widths (`ADDR_WIDTH` = 4, `DATA_WIDTH` = 16, `MEM_DEPTH` = 16, `AUTO_INC` = 0):**
  - Write 0xBEEF at address 0x3, then send 11 twice.
  - Expect 0xBEEF on both reads, showing `rd_ptr` does not advance.
  - Also send 00 with payload 0xFFF3 and expect it to select address 0x3 with no error.
